// File: rtl/linear_request_scheduler.sv
// Round-robin scheduler that shares one linear AXI address generator between NUM_REQ requesters.
// One descriptor is in flight at a time; completion is reported to its owner with a one-cycle pulse.
module linear_request_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 8
) (
   input  logic                          aclk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            reqValid,
   output logic [NUM_REQ-1:0]            reqReady,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqStartAddr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqSizeInBeats,
   output logic [NUM_REQ-1:0]            reqDone,
   output logic                          genStart,
   input  logic                          genDone,
   output logic [ADDR_WIDTH-1:0]         genStartAddr,
   output logic [ADDR_WIDTH-1:0]         genDataSizeInBeats,
   output logic [ID_WIDTH-1:0]           activeId,
   output logic                          busy
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, COMPLETE} state_t;

   state_t                 state, state_nxt;
   logic [PTR_W-1:0]       rr_ptr, winner;
   logic                   found, grant;
   logic [NUM_REQ-1:0]     done_nxt;
   logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
   logic [ADDR_WIDTH-1:0]  size_arr [NUM_REQ];

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
      one_hot      = '0;
      one_hot[idx] = 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = reqStartAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign size_arr[i] = reqSizeInBeats[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Search starts one past the last winner and wraps modulo NUM_REQ.
   always_comb begin : rr_search
      int               idx;
      logic [PTR_W-1:0] cand;
      winner = rr_ptr;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PTR_W'(idx);
         if (!found && reqValid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign grant = (state == IDLE) && genDone && found;
   assign busy  = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      genStart  = 1'b0;
      reqReady  = '0;
      done_nxt  = '0;
      case (state)
         IDLE: begin
            if (grant) begin
               reqReady  = one_hot(winner);
               state_nxt = (|size_arr[winner]) ? START : COMPLETE;
            end
         end
         START: begin
            genStart = 1'b1;
            if (!genDone) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (genDone) state_nxt = COMPLETE;
         end
         COMPLETE: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (state_nxt == COMPLETE && state != COMPLETE) done_nxt = one_hot(grant ? winner : rr_ptr);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state              <= IDLE;
         rr_ptr             <= PTR_W'(NUM_REQ - 1);
         genStartAddr       <= '0;
         genDataSizeInBeats <= '0;
         activeId           <= '0;
         reqDone            <= '0;
      end else begin
         state   <= state_nxt;
         reqDone <= done_nxt;
         if (grant) begin
            genStartAddr       <= addr_arr[winner];
            genDataSizeInBeats <= size_arr[winner];
            activeId           <= ID_WIDTH'(winner);
            rr_ptr             <= winner;
         end
      end
   end

endmodule

// File: doc/linear_request_scheduler.md
# linear_request_scheduler

Round-robin scheduler that shares one linear AXI address generator between `NUM_REQ` requesters, such as framebuffer, texture and display streams. Each requester posts a transfer descriptor with a start address and a size in beats. The scheduler grants one descriptor at a time, drives the generator's `start`/`done` handshake, and reports completion to the owning requester. It sits between the stream clients and the generator instance that feeds the memory AXI read or write address channel.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16).
- `ADDR_WIDTH`, 32, width of addresses and beat counts; matches the generator.
- `ID_WIDTH`, 8, width of `activeId`; must satisfy `ID_WIDTH >= clog2(NUM_REQ)`.

Ports:
- `aclk` in 1: the single clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `reqValid` in `NUM_REQ`: per-requester descriptor valid.
- `reqReady` out `NUM_REQ`: one-hot, combinational acceptance strobe.
- `reqStartAddr` in `NUM_REQ*ADDR_WIDTH`: byte start address; slice i belongs to requester i.
- `reqSizeInBeats` in `NUM_REQ*ADDR_WIDTH`: transfer length in beats; slice i belongs to requester i.
- `reqDone` out `NUM_REQ`: one-hot, registered, one-cycle completion pulse.
- `genStart` out 1: start strobe to the generator.
- `genDone` in 1: generator idle flag (1 = idle).
- `genStartAddr` out `ADDR_WIDTH`: latched start address.
- `genDataSizeInBeats` out `ADDR_WIDTH`: latched size.
- `activeId` out `ID_WIDTH`: granted requester index, zero-extended.
- `busy` out 1: high in every state except IDLE.

## Operation
- State machine states: IDLE, START, WAIT_DONE, COMPLETE.
- **IDLE.** When `genDone`=1 and any `reqValid` is set, select a winner by round-robin.
  - The search begins at `rrPtr+1` modulo `NUM_REQ`. `rrPtr` is the index of the last winner.
  - Assert `reqReady[winner]` combinationally in the same cycle.
  - On the clock edge, latch the winner's address and size into `genStartAddr`/`genDataSizeInBeats`, load `activeId` and `rrPtr` with the winner, and leave IDLE.
  - If the latched size is nonzero, go to START. If the size is 0, go to COMPLETE without starting the generator.
- **IDLE with `genDone`=0** (generator not idle): grant nothing and assert no `reqReady`.
- **START.** `genStart`=1.
  - Stay while `genDone`=1.
  - When `genDone`=0 is observed, the generator has accepted the start; go to WAIT_DONE.
  - `genStart` may still be 1 in that observing cycle. This is harmless because the generator only samples start while it is idle.
- **WAIT_DONE.** `genStart`=0. Go to COMPLETE when `genDone`=1.
- **COMPLETE.** `reqDone[activeId]`=1 for exactly this one cycle, then go to IDLE.
- Requester obligations:
  - Hold `reqValid` and the payload stable until `reqReady`.
  - `reqValid` may be high again in the `reqDone` cycle. That request is arbitrated in the following IDLE cycle.
- A requester whose `reqValid` drops before it is granted is skipped. No state is kept per requester except `rrPtr`.
- Width rules:
  - The address and size registers are `ADDR_WIDTH` wide, with no arithmetic on them.
  - `rrPtr` is `clog2(NUM_REQ)` bits wide and wraps modulo `NUM_REQ` for non-power-of-two `NUM_REQ`.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - `rrPtr` = `NUM_REQ-1`, so requester 0 has first priority
  - `genStartAddr`, `genDataSizeInBeats`, `activeId` = 0
  - `reqDone`, `genStart`, `busy`, `reqReady` = 0
- Grant latency: `reqReady` rises in the same cycle that `reqValid` and `genDone` are both high while in IDLE.
- `genStart` is high starting from the next cycle.
- Minimum nonzero-size turnaround is 4 cycles: IDLE → START → WAIT_DONE → COMPLETE, assuming the generator is idle one cycle after its done drops.
- `reqDone` fires exactly 1 cycle after `genDone` is seen rising in WAIT_DONE.
- Zero-size turnaround: IDLE → COMPLETE → IDLE, with `reqDone` pulsing 1 cycle after `reqReady`.
- Between two grants there is at least one IDLE cycle.
- Reset mid-operation: return to IDLE and clear all outputs. No `reqDone` is issued for the aborted transfer. The generator shares `resetn`.

## Test plan
- **Single request.** Requester 2 posts addr 0x1000, size 64; generator model drops `genDone` 1 cycle after start and holds it low 4 cycles.
  - Expect `reqReady`=0b0100 for one cycle.
  - Expect `genStart` for 2 cycles, with `genStartAddr`=0x1000 and `genDataSizeInBeats`=64.
  - Expect `reqDone`=0b0100 exactly once, 1 cycle after `genDone` rises.
- **Round-robin.** Requesters 0, 1 and 3 hold `reqValid` continuously.
  - Expect grant order 0, 1, 3, 0, 1, 3.
  - `activeId` matches each grant, and `reqDone` is one-hot and ordered the same way.
- **Zero size.** Requester 1 posts size 0.
  - `genStart` never asserts.
  - `reqDone`=0b0010 arrives 1 cycle after `reqReady`.
- **Generator not idle.** `genDone` is held 0 externally while requester 0 is valid.
  - No `reqReady` and no `genStart`.
  - After `genDone` rises, the grant occurs in that same cycle.
- **Reset mid-transfer.** Assert `resetn`=0 while in WAIT_DONE.
  - Outputs clear immediately, and no `reqDone` is issued.
  - After release with requesters 2 and 3 valid, requester 2 is granted first (round-robin restarts from index 0).
- **Re-request in the done cycle.** Requester 0 reasserts `reqValid` in its `reqDone` cycle while requester 1 is waiting.
  - Requester 1 is granted next, then requester 0.
